// File: rtl/buff_tx.sv
// buff_tx: buffered UART-style transmitter.
// A one-entry holding buffer feeds a shift register. Each frame is a start
// bit, eight data bits LSB first, an even-parity bit and a stop bit.
// Frames run back to back whenever the buffer is refilled before a stop bit ends.
module buff_tx #(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [7:0] tx_byte,
  input  logic       send,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       buf_full,
  output logic       tx_done,
  output logic       err_LED
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            tx_q, tx_d;
  logic [7:0]      buf_q, buf_d;
  logic            buf_full_q, buf_full_d;
  logic            err_q, err_d;
  logic            load;
  logic            done;
  logic            bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  // Holding buffer: accept on an empty buffer, flag overflow on a full one.
  // Acceptance looks only at the registered buf_full_q, so a send on the edge
  // that empties the buffer is still treated as an overflow.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    err_d      = err_q;
    if (send) begin
      if (!buf_full_q) begin
        buf_d      = tx_byte;
        buf_full_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    // load only fires with buf_full_q=1, acceptance only with buf_full_q=0.
    if (load) begin
      buf_full_d = 1'b0;
    end
  end

  // Frame sequencer: bit timing, shifting and the registered serial line value.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    load     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (buf_full_q) begin
          load = 1'b1;
        end
      end
      START, DATA, PARITY, STOP: begin
        if (!bit_end) begin
          baud_d = baud_q + CW'(1);
        end else begin
          baud_d = '0;
          unique case (state_q)
            START: begin
              state_d = DATA;
              bit_d   = '0;
              tx_d    = shift_q[0];
            end
            DATA: begin
              if (bit_q == 3'd7) begin
                state_d = PARITY;
                tx_d    = parity_q;
              end else begin
                shift_d = shift_q >> 1;
                tx_d    = shift_q[1];
                bit_d   = bit_q + 3'd1;
              end
            end
            PARITY: begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
            default: begin // STOP
              done = 1'b1;
              if (buf_full_q) begin
                load = 1'b1;
              end else begin
                state_d = IDLE;
                tx_d    = 1'b1;
              end
            end
          endcase
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Moving the buffered byte into the shift register starts a new frame.
    if (load) begin
      state_d  = START;
      shift_d  = buf_q;
      parity_d = ^buf_q;
      tx_d     = 1'b0;
      baud_d   = '0;
      bit_d    = '0;
    end
  end

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      // NOTE: the buffer data is reset too; it is a single register, and
      // clearing it guarantees nothing stale is ever replayed after reset.
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      err_q      <= err_d;
    end
  end

  assign tx_serial = tx_q;
  assign tx_busy   = (state_q != IDLE);
  assign buf_full  = buf_full_q;
  assign tx_done   = done;
  assign err_LED   = err_q;

endmodule

// File: tb/tb_buff_tx.sv
// Directed bench for buff_tx at CLKS_PER_BIT=4. Inputs change and outputs
// are sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_buff_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       send = 1'b0;
  logic       tx_serial, tx_busy, buf_full, tx_done, err_LED;

  int n_checks = 0;
  int n_fail   = 0;

  buff_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .nRst      (nRst),
    .tx_byte   (tx_byte),
    .send      (send),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .buf_full  (buf_full),
    .tx_done   (tx_done),
    .err_LED   (err_LED)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Idle outputs: line high, nothing busy, optional expected error flag.
  task automatic check_idle(input string tag, input logic exp_err);
    check({tag, " tx_serial"}, tx_serial, 1'b1);
    check({tag, " tx_busy"},   tx_busy,   1'b0);
    check({tag, " buf_full"},  buf_full,  1'b0);
    check({tag, " tx_done"},   tx_done,   1'b0);
    check({tag, " err_LED"},   err_LED,   exp_err);
  endtask

  // Called at the falling edge of the first start-bit cycle; returns at the
  // falling edge of the first cycle after the frame.
  task automatic check_frame(input logic [7:0] b);
    logic [10:0] bits;
    bits = {1'b1, ^b, b, 1'b0};
    for (int i = 0; i < 11 * CPB; i++) begin
      check($sformatf("frame %02h tx_serial c%0d", b, i), tx_serial, bits[i / CPB]);
      check($sformatf("frame %02h tx_done c%0d", b, i), tx_done, (i == 11 * CPB - 1));
      check($sformatf("frame %02h tx_busy c%0d", b, i), tx_busy, 1'b1);
      @(negedge clk);
    end
  endtask

  // Single-cycle send from idle; returns at the falling edge after the
  // frame has started (line already low).
  task automatic send_byte(input logic [7:0] b);
    tx_byte = b;
    send    = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check("accept buf_full", buf_full, 1'b1);
    check("accept tx_serial", tx_serial, 1'b1);
    check("accept tx_busy", tx_busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, both while held and after release.
    @(negedge clk);
    check_idle("in reset", 1'b0);
    nRst = 1'b1;
    @(negedge clk);
    check_idle("after reset", 1'b0);

    // Single frame 0x41: 0,1,0,0,0,0,0,1,0,parity 0,1.
    send_byte(8'h41);
    check_frame(8'h41);
    check_idle("after 41", 1'b0);

    // 0x41 then 0x07 mid-frame: 0x07 (parity 1) follows with no gap.
    send_byte(8'h41);
    fork
      begin
        repeat (9) @(negedge clk);
        tx_byte = 8'h07;
        send    = 1'b1;
        @(negedge clk);
        send    = 1'b0;
        tx_byte = 8'hFF;
        check("queued 07 buf_full", buf_full, 1'b1);
      end
      begin
        check_frame(8'h41);
        check_frame(8'h07);
      end
    join
    check_idle("after 41,07", 1'b0);

    // Three consecutive sends from idle: the second lands on the edge that
    // empties the buffer and is dropped, the third refills it.
    fork
      begin
        tx_byte = 8'h41;
        send    = 1'b1;
        @(negedge clk);
        tx_byte = 8'h07;
        @(negedge clk);
        tx_byte = 8'h55;
        @(negedge clk);
        send = 1'b0;
      end
      begin
        @(negedge clk);
        check("burst buf_full", buf_full, 1'b1);
        @(negedge clk);
        check("burst err_LED", err_LED, 1'b1);
        check_frame(8'h41);
        check_frame(8'h55);
      end
    join
    check_idle("after burst", 1'b1);
    do_reset();
    check_idle("err cleared", 1'b0);

    // 0x41, then 0x07 and 0x55 on consecutive cycles once the buffer has
    // emptied: 0x07 is queued, 0x55 is dropped.
    fork
      begin
        tx_byte = 8'h41;
        send    = 1'b1;
        @(negedge clk);
        send = 1'b0;
        @(negedge clk);
        tx_byte = 8'h07;
        send    = 1'b1;
        @(negedge clk);
        tx_byte = 8'h55;
        @(negedge clk);
        send = 1'b0;
      end
      begin
        @(negedge clk);
        @(negedge clk);
        check("overflow err before", err_LED, 1'b0);
        check_frame(8'h41);
        check_frame(8'h07);
      end
    join
    check_idle("after overflow", 1'b1);
    repeat (5) @(negedge clk);
    check("err_LED sticky", err_LED, 1'b1);
    do_reset();
    check_idle("err cleared 2", 1'b0);

    // Reset during data bit 3 of 0xA5 (bit 3 is 0, so the forced 1 is visible).
    send_byte(8'hA5);
    repeat (17) @(negedge clk);
    check("A5 bit3 before reset", tx_serial, 1'b0);
    nRst = 1'b0;
    #1;
    check_idle("mid-frame reset", 1'b0);
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check($sformatf("post-reset idle tx c%0d", i), tx_serial, 1'b1);
      check($sformatf("post-reset idle busy c%0d", i), tx_busy, 1'b0);
    end
    send_byte(8'h3C);
    check_frame(8'h3C);
    check_idle("after 3C", 1'b0);

    // send held high for 100 cycles with 0x10 (parity 1).
    fork
      begin
        tx_byte = 8'h10;
        send    = 1'b1;
        repeat (100) @(negedge clk);
        send = 1'b0;
      end
      begin
        @(negedge clk);
        check("hold buf_full", buf_full, 1'b1);
        check("hold err before", err_LED, 1'b0);
        @(negedge clk);
        check("hold err on transfer", err_LED, 1'b1);
        check_frame(8'h10);
        check_frame(8'h10);
      end
    join
    check("hold refilled buf_full", buf_full, 1'b1);
    check("hold err_LED", err_LED, 1'b1);
    check("hold busy", tx_busy, 1'b1);
    do_reset();
    check_idle("final reset", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
